// File: rtl/threshold_alarm_if.sv
// threshold_alarm_if: sample/threshold input bundle and compare/alarm result bundle.
// master drives samples and collects results; slave is the alarm stage.
interface threshold_alarm_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic [N-1:0] sample;
  logic [N-1:0] threshold;
  logic         clr;
  logic         cmp_eq;
  logic         cmp_gt;
  logic         cmp_lt;
  logic         alarm;
  logic         alarm_rise;
  logic         alarm_fall;
  logic [7:0]   event_count;

  modport master (
    output in_valid, sample, threshold, clr,
    input  cmp_eq, cmp_gt, cmp_lt, alarm, alarm_rise, alarm_fall, event_count
  );

  modport slave (
    input  in_valid, sample, threshold, clr,
    output cmp_eq, cmp_gt, cmp_lt, alarm, alarm_rise, alarm_fall, event_count
  );
endinterface

// File: rtl/threshold_alarm.sv
// threshold_alarm: registered compare plus K-sample hysteresis alarm with edge pulses.
// Optional saturating rise-event counter is built when THRESH_EVENT_CNT_EN is defined.
module threshold_alarm #(
  parameter int N = 4,
  parameter int K = 3
) (
  input logic              clk,
  input logic              rst_n,
  threshold_alarm_if.slave bus
);
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    PEND_HI = 2'd1,
    ALARM   = 2'd2,
    PEND_LO = 2'd3
  } state_t;

  localparam logic [7:0] K_C = 8'(K);

  state_t       state_r;
  state_t       state_nx_s;
  logic [7:0]   cnt_r;
  logic [7:0]   cnt_nx_s;
  logic [7:0]   cnt_inc_s;
  logic [N-1:0] sample_s;
  logic [N-1:0] threshold_s;
  logic         hi_s;
  logic         lo_s;
  logic         rise_s;
  logic         fall_s;
  logic         alarm_nx_s;
  logic         cmp_eq_r;
  logic         cmp_gt_r;
  logic         cmp_lt_r;
  logic         alarm_r;
  logic         rise_r;
  logic         fall_r;
  logic [7:0]   event_count_r;

  assign sample_s    = bus.sample;
  assign threshold_s = bus.threshold;
  assign hi_s        = (sample_s > threshold_s);
  assign lo_s        = (sample_s < threshold_s);
  assign cnt_inc_s   = cnt_r + 8'd1;

  // Next-state and pulse decode; an equal sample leaves state and run count untouched.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    rise_s     = 1'b0;
    fall_s     = 1'b0;
    if (bus.in_valid) begin
      case (state_r)
        NORMAL: begin
          if (hi_s) begin
            if (K_C == 8'd1) begin
              state_nx_s = ALARM;
              cnt_nx_s   = 8'd0;
              rise_s     = 1'b1;
            end else begin
              state_nx_s = PEND_HI;
              cnt_nx_s   = 8'd1;
            end
          end else begin
            state_nx_s = NORMAL;
          end
        end
        PEND_HI: begin
          if (hi_s) begin
            if (cnt_inc_s == K_C) begin
              state_nx_s = ALARM;
              cnt_nx_s   = 8'd0;
              rise_s     = 1'b1;
            end else begin
              cnt_nx_s = cnt_inc_s;
            end
          end else if (lo_s) begin
            state_nx_s = NORMAL;
            cnt_nx_s   = 8'd0;
          end else begin
            state_nx_s = PEND_HI;
          end
        end
        ALARM: begin
          if (lo_s) begin
            if (K_C == 8'd1) begin
              state_nx_s = NORMAL;
              cnt_nx_s   = 8'd0;
              fall_s     = 1'b1;
            end else begin
              state_nx_s = PEND_LO;
              cnt_nx_s   = 8'd1;
            end
          end else begin
            state_nx_s = ALARM;
          end
        end
        PEND_LO: begin
          if (lo_s) begin
            if (cnt_inc_s == K_C) begin
              state_nx_s = NORMAL;
              cnt_nx_s   = 8'd0;
              fall_s     = 1'b1;
            end else begin
              cnt_nx_s = cnt_inc_s;
            end
          end else if (hi_s) begin
            state_nx_s = ALARM;
            cnt_nx_s   = 8'd0;
          end else begin
            state_nx_s = PEND_LO;
          end
        end
        default: begin
          state_nx_s = NORMAL;
          cnt_nx_s   = 8'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  assign alarm_nx_s = (state_nx_s == ALARM) || (state_nx_s == PEND_LO);

  // State, run counter and registered compare/alarm outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= NORMAL;
      cnt_r    <= 8'd0;
      cmp_eq_r <= 1'b0;
      cmp_gt_r <= 1'b0;
      cmp_lt_r <= 1'b0;
      alarm_r  <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      alarm_r <= alarm_nx_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      if (bus.in_valid) begin
        cmp_eq_r <= !hi_s && !lo_s;
        cmp_gt_r <= hi_s;
        cmp_lt_r <= lo_s;
      end else begin
        cmp_eq_r <= cmp_eq_r;
        cmp_gt_r <= cmp_gt_r;
        cmp_lt_r <= cmp_lt_r;
      end
    end
  end

`ifdef THRESH_EVENT_CNT_EN
  // Saturating rise counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      event_count_r <= 8'd0;
    end else if (bus.clr) begin
      event_count_r <= 8'd0;
    end else if (rise_s && (event_count_r != 8'd255)) begin
      event_count_r <= event_count_r + 8'd1;
    end else begin
      event_count_r <= event_count_r;
    end
  end
`else
  assign event_count_r = 8'd0;
`endif

  assign bus.cmp_eq      = cmp_eq_r;
  assign bus.cmp_gt      = cmp_gt_r;
  assign bus.cmp_lt      = cmp_lt_r;
  assign bus.alarm       = alarm_r;
  assign bus.alarm_rise  = rise_r;
  assign bus.alarm_fall  = fall_r;
  assign bus.event_count = event_count_r;
endmodule
